wrr_arb_top: RTL and testbench

Weighted round-robin arbiter and successor to rr_top. It arbitrates among REQCNT requesters and gives each winner a burst of up to weight_i[k] back-to-back grants. The grant goes out on a valid/ready handshake so a downstream consumer can apply backpressure. The block also keeps a saturating per-channel wait-time statistic and publishes the worst case, for latency characterisation in system benches.

---
 rtl/wrr_arb_top.sv | 147 ++++++++++++++
 tb/tb_wrr_arb_top.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wrr_arb_top.sv
// Weighted round-robin arbiter: registered valid/ready grant with per-winner
// burst credit, plus saturating per-channel wait counters and a worst-case tracker.
module wrr_arb_top #(
  parameter int REQCNT   = 16,
  parameter int WEIGHT_W = 4,
  parameter int WAIT_W   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [REQCNT-1:0]            req_i,
  input  logic                         req_val_i,
  input  logic [REQCNT*WEIGHT_W-1:0]   weight_i,
  output logic [$clog2(REQCNT)-1:0]    req_num_o,
  output logic                         req_num_val_o,
  input  logic                         req_num_rdy_i,
  output logic [WAIT_W-1:0]            max_wait_o,
  input  logic                         max_wait_clr_i
);
  localparam int IDX_W = $clog2(REQCNT);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    num_q, num_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WAIT_W-1:0]   wait_q [REQCNT];
  logic [WAIT_W-1:0]   wait_d [REQCNT];
  logic [WAIT_W-1:0]   max_q, max_d;

  logic                xfer_s;
  logic [IDX_W-1:0]    base_s;
  logic [IDX_W-1:0]    win_s;
  logic                win_found_s;
  logic [WEIGHT_W-1:0] win_weight_s;
  logic [WEIGHT_W-1:0] fresh_credit_s;

  assign xfer_s = (state_q == ST_GRANT) && req_num_rdy_i;
  // On a transfer the just-served channel becomes the search base, so it is the last candidate.
  assign base_s = xfer_s ? num_q : ptr_q;

  // Round-robin search starting at base+1 with modulo-REQCNT wrap.
  always_comb begin
    logic [IDX_W:0]   sum_v;
    logic [IDX_W-1:0] idx_v;
    win_found_s = 1'b0;
    win_s       = '0;
    sum_v       = '0;
    idx_v       = '0;
    for (int i = 1; i <= REQCNT; i++) begin
      sum_v = {1'b0, base_s} + (IDX_W+1)'(i);
      idx_v = (sum_v >= (IDX_W+1)'(REQCNT)) ? IDX_W'(sum_v - (IDX_W+1)'(REQCNT))
                                            : sum_v[IDX_W-1:0];
      win_s       = (!win_found_s && req_i[idx_v]) ? idx_v : win_s;
      win_found_s = win_found_s | req_i[idx_v];
    end
  end

  // Winner's weight and the credit it starts with (weight 0 behaves as 1).
  always_comb begin
    win_weight_s = '0;
    for (int k = 0; k < REQCNT; k++) begin
      win_weight_s = (win_s == IDX_W'(k)) ? weight_i[k*WEIGHT_W +: WEIGHT_W] : win_weight_s;
    end
    fresh_credit_s = (win_weight_s == '0) ? '0 : win_weight_s - WEIGHT_W'(1);
  end

  // Grant FSM next state.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val_i && win_found_s) begin
          state_d  = ST_GRANT;
          num_d    = win_s;
          credit_d = fresh_credit_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!xfer_s) begin
          state_d = ST_GRANT;
        end else if ((credit_q != '0) && req_i[num_q] && req_val_i) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          ptr_d = num_q;
          if (req_val_i && win_found_s) begin
            num_d    = win_s;
            credit_d = fresh_credit_s;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating wait counters and the running maximum of their next values.
  always_comb begin
    logic [WAIT_W-1:0] max_v;
    max_v = max_q;
    for (int k = 0; k < REQCNT; k++) begin
      if (req_i[k] && !(xfer_s && (num_q == IDX_W'(k)))) begin
        wait_d[k] = (wait_q[k] == {WAIT_W{1'b1}}) ? wait_q[k] : wait_q[k] + WAIT_W'(1);
      end else begin
        wait_d[k] = '0;
      end
      max_v = (wait_d[k] > max_v) ? wait_d[k] : max_v;
    end
    max_d = max_wait_clr_i ? '0 : max_v;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      ptr_q    <= IDX_W'(REQCNT-1);
      credit_q <= '0;
      max_q    <= '0;
      for (int k = 0; k < REQCNT; k++) begin
        wait_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      max_q    <= max_d;
      for (int k = 0; k < REQCNT; k++) begin
        wait_q[k] <= wait_d[k];
      end
    end
  end

  assign req_num_o     = num_q;
  assign req_num_val_o = (state_q == ST_GRANT);
  assign max_wait_o    = max_q;

endmodule

// File: tb/tb_wrr_arb_top.sv
// Directed bench: vector table on a 4-channel arbiter, hand sequence on a 16-channel one.
module tb_wrr_arb_top;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rv4, rdy4, clr4, val4;
  logic [3:0]  req4;
  logic [15:0] w4, max4;
  logic [1:0]  num4;

  logic        rst16, rv16, rdy16, clr16, val16;
  logic [15:0] req16, max16;
  logic [63:0] w16;
  logic [3:0]  num16;

  wrr_arb_top #(.REQCNT(4), .WEIGHT_W(4), .WAIT_W(16)) dut4 (
    .clk_i(clk), .rst_i(rst4), .req_i(req4), .req_val_i(rv4), .weight_i(w4),
    .req_num_o(num4), .req_num_val_o(val4), .req_num_rdy_i(rdy4),
    .max_wait_o(max4), .max_wait_clr_i(clr4)
  );

  wrr_arb_top #(.REQCNT(16), .WEIGHT_W(4), .WAIT_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst16), .req_i(req16), .req_val_i(rv16), .weight_i(w16),
    .req_num_o(num16), .req_num_val_o(val16), .req_num_rdy_i(rdy16),
    .max_wait_o(max16), .max_wait_clr_i(clr16)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic        rv;
    logic        rdy;
    logic [15:0] w;
    logic        clr;
    logic        exp_val;
    logic [1:0]  exp_num;
    logic        chk_max;
    logic [15:0] exp_max;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic add(input string nm, input logic r, input logic [3:0] rq, input logic rv,
                     input logic rdy, input logic [15:0] w, input logic clr, input logic ev,
                     input logic [1:0] en, input logic cm, input logic [15:0] em);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.rv = rv; v.rdy = rdy; v.w = w; v.clr = clr;
    v.exp_val = ev; v.exp_num = en; v.chk_max = cm; v.exp_max = em;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst4 = 1'b1; rv4 = 1'b0; rdy4 = 1'b0; clr4 = 1'b0; req4 = 4'h0; w4 = 16'h1111;
    rst16 = 1'b1; rv16 = 1'b0; rdy16 = 1'b0; clr16 = 1'b0; req16 = 16'h0000; w16 = {16{4'h1}};

    // name, rst, req, rv, rdy, weights, clr, exp_val, exp_num, chk_max, exp_max
    add("t1_rst", 1'b1, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b1, 16'd0);
    add("t1",     1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t1",     1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);
    add("t1",     1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd2, 1'b0, 16'd0);
    add("t1",     1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd3, 1'b1, 16'd4);
    add("t1",     1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t1",     1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);

    add("t2_rst", 1'b1, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b0, 2'd0, 1'b1, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd2, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd3, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd3, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t2",     1'b0, 4'hF, 1'b1, 1'b1, 16'h2013, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);

    // Backpressure: grant to 1 held while req/req_val wiggle; one transfer, then re-grant.
    add("t3_rst", 1'b1, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    add("t3",     1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b1, 16'd1);
    add("t3",     1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);
    add("t3",     1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);
    add("t3",     1'b0, 4'h0, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b1, 16'd3);
    add("t3",     1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);
    add("t3",     1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b0, 16'd0);
    add("t3_xfer",1'b0, 4'h2, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b1, 16'd3);
    add("t3_clr", 1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 2'd1, 1'b1, 16'd0);
    add("t3",     1'b0, 4'h2, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b1, 16'd2);

    add("t5_rst", 1'b1, 4'h5, 1'b1, 1'b1, 16'h1114, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    add("t5",     1'b0, 4'h5, 1'b1, 1'b1, 16'h1114, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t5",     1'b0, 4'h5, 1'b1, 1'b1, 16'h1114, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t5_drop",1'b0, 4'h4, 1'b1, 1'b1, 16'h1114, 1'b0, 1'b1, 2'd2, 1'b0, 16'd0);
    add("t5",     1'b0, 4'h4, 1'b1, 1'b1, 16'h1114, 1'b0, 1'b1, 2'd2, 1'b0, 16'd0);

    add("t6_rst", 1'b1, 4'hF, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    add("t6_noval",1'b0,4'hF, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    add("t6",     1'b0, 4'hF, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t6",     1'b0, 4'hF, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    add("t6_mid", 1'b1, 4'hF, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b1, 16'd0);
    add("t6_rel", 1'b0, 4'hF, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst4 = vecs[i].rst; req4 = vecs[i].req; rv4 = vecs[i].rv;
      rdy4 = vecs[i].rdy; w4 = vecs[i].w; clr4 = vecs[i].clr;
      @(posedge clk); #1;
      chk({vecs[i].name, "_val"}, i, 32'(val4), 32'(vecs[i].exp_val));
      chk({vecs[i].name, "_num"}, i, 32'(num4), 32'(vecs[i].exp_num));
      if (vecs[i].chk_max) begin
        chk({vecs[i].name, "_max"}, i, 32'(max4), 32'(vecs[i].exp_max));
      end
    end

    // 16 channels, upper half requesting: order 8..15, startup worst wait 8, steady 7.
    rst16 = 1'b1; req16 = 16'hFF00; rv16 = 1'b1; rdy16 = 1'b1; clr16 = 1'b0;
    @(posedge clk); #1;
    chk("t4_rst_val", 0, 32'(val16), 32'd0);
    chk("t4_rst_max", 0, 32'(max16), 32'd0);
    rst16 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      clr16 = (k == 32);
      @(posedge clk); #1;
      chk("t4_val", k, 32'(val16), 32'd1);
      chk("t4_num", k, 32'(num16), 32'(8 + (k % 8)));
      if (k == 31) chk("t4_max_pre", k, 32'(max16), 32'd8);
      if (k == 32) chk("t4_max_clr", k, 32'(max16), 32'd0);
      if (k > 32)  chk("t4_max", k, 32'(max16), 32'd7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
